// File: rtl/host_mem_ctrl.sv
// Host-side command sequencer for the 4-thread core: converts level-based software
// registers into single write strobes and timed reads on the IMEM/DMEM ports, and gates core run.
module host_mem_ctrl #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              sys_rstb,
    input  logic [31:0]       sw_mem_addr,
    input  logic [31:0]       sw_mem_wdata,
    input  logic [31:0]       sw_mem_cmd,
    input  logic [31:0]       sw_run,
    output logic              core_rstb,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_wen,
    output logic [DATA_W-1:0] imem_wdata,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic              dmem_wen,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [31:0]       hw_mem_rdata,
    output logic [31:0]       hw_status
);

    typedef enum logic [2:0] {IDLE, WR, RD, DONE, ERR} state_t;

    localparam logic [1:0] RD_LAST = 2'(RD_LAT);

    state_t      state;
    logic        cmd_prev;
    logic        run_q;
    logic        sel_dmem;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  rd_cnt;
    logic [15:0] wr_count;

    logic        cmd_nz;
    logic        accept;
    logic        is_iwr;
    logic        is_ird;
    logic        is_dwr;
    logic        is_drd;
    logic        unused_bits;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign cmd_nz = |sw_mem_cmd;
    assign is_iwr = (sw_mem_cmd == 32'd1);
    assign is_ird = (sw_mem_cmd == 32'd2);
    assign is_dwr = (sw_mem_cmd == 32'd3);
    assign is_drd = (sw_mem_cmd == 32'd4);
    // Only a 0 -> nonzero edge on the command register starts a transaction.
    assign accept = (state == IDLE) && cmd_nz && !cmd_prev;

    assign core_rstb   = run_q && (state == IDLE);
    assign hw_status   = {wr_count, 12'd0, core_rstb, error, done, busy};
    assign unused_bits = ^{sw_run[31:1], sw_mem_addr[31:ADDR_W]};

    always_ff @(posedge clk or negedge sys_rstb) begin
        if (!sys_rstb) begin
            state        <= IDLE;
            cmd_prev     <= 1'b0;
            run_q        <= 1'b0;
            sel_dmem     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            rd_cnt       <= 2'd0;
            wr_count     <= 16'd0;
            imem_addr    <= '0;
            imem_wen     <= 1'b0;
            imem_wdata   <= '0;
            dmem_addr    <= '0;
            dmem_wen     <= 1'b0;
            dmem_wdata   <= '0;
            hw_mem_rdata <= 32'd0;
        end else begin
            cmd_prev <= cmd_nz;
            run_q    <= sw_run[0];
            imem_wen <= 1'b0;
            dmem_wen <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        error  <= 1'b0;
                        done   <= 1'b0;
                        rd_cnt <= 2'd0;
                        // A running core owns the memories, so any command then is rejected.
                        if (core_rstb || !(is_iwr || is_ird || is_dwr || is_drd)) begin
                            error <= 1'b1;
                            state <= ERR;
                        end else begin
                            busy     <= 1'b1;
                            sel_dmem <= is_dwr || is_drd;
                            if (is_iwr || is_ird) begin
                                imem_addr <= sw_mem_addr[ADDR_W-1:0];
                            end else begin
                                dmem_addr <= sw_mem_addr[ADDR_W-1:0];
                            end
                            if (is_iwr) begin
                                imem_wen   <= 1'b1;
                                imem_wdata <= DATA_W'(sw_mem_wdata);
                            end
                            if (is_dwr) begin
                                dmem_wen   <= 1'b1;
                                dmem_wdata <= DATA_W'(sw_mem_wdata);
                            end
                            state <= (is_iwr || is_dwr) ? WR : RD;
                        end
                    end
                end
                WR: begin
                    wr_count   <= sat_inc(wr_count);
                    imem_addr  <= '0;
                    imem_wdata <= '0;
                    dmem_addr  <= '0;
                    dmem_wdata <= '0;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    state      <= DONE;
                end
                RD: begin
                    // Address is held for RD_LAT+1 cycles so the memory output settles before capture.
                    if (rd_cnt == RD_LAST) begin
                        hw_mem_rdata <= sel_dmem ? 32'(dmem_rdata) : 32'(imem_rdata);
                        imem_addr    <= '0;
                        dmem_addr    <= '0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state        <= DONE;
                    end else begin
                        rd_cnt <= rd_cnt + 2'd1;
                    end
                end
                DONE: begin
                    if (!cmd_nz) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                ERR: begin
                    if (!cmd_nz) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
